// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
`timescale 1ns/1ps
package ifetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto an instruction-word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    align_pc = pc & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: DEPTH entries of fetch_entry_t with a synchronous flush.
// Pointers wrap naturally because DEPTH is a power of two.
`timescale 1ns/1ps
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  fetch_entry_t               i_wdata,
  output fetch_entry_t               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Entry storage: write the incoming entry at the tail slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_tail] <= i_wdata;
    end
  end

  // Head/tail pointers: flush rewinds both, otherwise advance per push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential fetch into a prefetch queue, with
// redirect (flush + restart) taking priority over enqueue and pop.
// Optional macro IFETCH_MISALIGN_EN enables the sticky misaligned-redirect
// fault; when undefined, fault is tied low and low address bits are dropped.
`timescale 1ns/1ps
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_wdata;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_fault;
  logic [XLEN-1:0]  w_redirect_aligned;

  assign w_redirect_aligned = align_pc(redirect_pc);
  assign w_valid            = (w_count != CNT_W'(0));
  assign w_wdata            = '{pc: r_fetch_pc, instr: imem_rd};

  // Handshake control: redirect voids both enqueue and pop this cycle.
  always_comb begin
    w_pop  = 1'b0;
    w_push = 1'b0;
    if (redirect) begin
      w_pop  = 1'b0;
      w_push = 1'b0;
    end else begin
      w_pop  = w_valid && instr_ready;
      w_push = ((w_count < CNT_W'(DEPTH)) || w_pop) && !w_fault;
    end
  end

  // Fetch address: reload on redirect, step one word per enqueue (wraps at 2^32).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_aligned;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
    end else begin
      r_fetch_pc <= r_fetch_pc;
    end
  end

`ifdef IFETCH_MISALIGN_EN
  logic r_fault;

  // Sticky fault: every redirect re-evaluates it from the target alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (redirect) begin
      r_fault <= (redirect_pc[1:0] != 2'b00);
    end else begin
      r_fault <= r_fault;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_a      = r_fetch_pc;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_head.instr : 32'h0000_0000;
  assign instr_pc    = w_valid ? w_head.pc    : 32'h0000_0000;
  assign fault       = w_fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit. ROM model: word at byte
// address a is (a >> 2) + 0x100. A second instance checks RESET_PC wrap.
`timescale 1ns/1ps
module tb_ifetch_unit;

  logic        clk;
  logic        reset, redirect, ready;
  logic [31:0] redirect_pc, imem_a, imem_rd, instr, instr_pc;
  logic        valid, fault;

  logic        reset2;
  logic [31:0] imem_a2, imem_rd2, instr2, instr_pc2;
  logic        valid2, fault2;

  int n_cmp;
  int n_fail;

  assign imem_rd  = (imem_a  >> 2) + 32'h0000_0100;
  assign imem_rd2 = (imem_a2 >> 2) + 32'h0000_0100;

  ifetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(valid), .instr_ready(ready), .instr(instr),
    .instr_pc(instr_pc), .fault(fault)
  );

  ifetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .imem_a(imem_a2), .imem_rd(imem_rd2),
    .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .instr_valid(valid2), .instr_ready(1'b1), .instr(instr2),
    .instr_pc(instr_pc2), .fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; redirect = 1'b0; ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    n_cmp++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (imem_a !== 32'h0) begin n_fail++; $display("FAIL reset_imem_a: got %h want 0", imem_a); end
    n_cmp++; if (imem_a2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_imem_a2: got %h want fffffff8", imem_a2); end
  endtask

  task automatic test_stream();
    do_reset();
    ready = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== 32'(k + 256)) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, valid, instr_pc, instr, 32'(4*k), 32'(k + 256));
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h100) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h i=%h want v=1 pc=0 i=100", c, valid, instr_pc, instr);
      end
    end
    n_cmp++; if (imem_a !== 32'h10) begin n_fail++; $display("FAIL stall_imem_a: got %h want 10", imem_a); end
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || instr_pc !== 32'(4*k) || instr !== 32'(k + 256)) begin
        n_fail++;
        $display("FAIL drain_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, valid, instr_pc, instr, 32'(4*k), 32'(k + 256));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ready = 1'b0;
    for (int c = 0; c < 5; c++) step();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || instr_pc !== 32'h0 || instr !== 32'h0 || imem_a !== 32'h40) begin
      n_fail++;
      $display("FAIL redir_gap: got v=%b pc=%h i=%h a=%h want v=0 pc=0 i=0 a=40", valid, instr_pc, instr, imem_a);
    end
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h110) begin
      n_fail++;
      $display("FAIL redir_first: got v=%b pc=%h i=%h want v=1 pc=40 i=110", valid, instr_pc, instr);
    end
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h44 || instr !== 32'h111) begin
      n_fail++;
      $display("FAIL redir_second: got v=%b pc=%h i=%h want v=1 pc=44 i=111", valid, instr_pc, instr);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_pc = 32'h304;
    step();
    redirect = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || imem_a !== 32'h304) begin
      n_fail++;
      $display("FAIL b2b_gap: got v=%b a=%h want v=0 a=304", valid, imem_a);
    end
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h304 || instr !== 32'h1C1) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b pc=%h i=%h want v=1 pc=304 i=1c1", valid, instr_pc, instr);
    end
  endtask

  task automatic test_misalign();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_EN
    n_cmp++;
    if (fault !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_set: got f=%b v=%b want f=1 v=0", fault, valid);
    end
    step();
    step();
    n_cmp++;
    if (fault !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_hold: got f=%b v=%b want f=1 v=0", fault, valid);
    end
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_clear: got f=%b v=%b want f=0 v=0", fault, valid);
    end
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h80 || instr !== 32'h120) begin
      n_fail++;
      $display("FAIL mis_resume: got v=%b pc=%h i=%h want v=1 pc=80 i=120", valid, instr_pc, instr);
    end
`else
    n_cmp++;
    if (fault !== 1'b0 || valid !== 1'b0 || imem_a !== 32'h40) begin
      n_fail++;
      $display("FAIL align_drop: got f=%b v=%b a=%h want f=0 v=0 a=40", fault, valid, imem_a);
    end
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h110) begin
      n_fail++;
      $display("FAIL align_resume: got v=%b pc=%h i=%h want v=1 pc=40 i=110", valid, instr_pc, instr);
    end
`endif
  endtask

  task automatic test_wrap();
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    step();
    n_cmp++;
    if (valid2 !== 1'b1 || instr_pc2 !== 32'hFFFF_FFF8 || instr2 !== 32'h4000_00FE) begin
      n_fail++;
      $display("FAIL wrap_0: got v=%b pc=%h i=%h want v=1 pc=fffffff8 i=400000fe", valid2, instr_pc2, instr2);
    end
    step();
    n_cmp++;
    if (valid2 !== 1'b1 || instr_pc2 !== 32'hFFFF_FFFC || instr2 !== 32'h4000_00FF) begin
      n_fail++;
      $display("FAIL wrap_1: got v=%b pc=%h i=%h want v=1 pc=fffffffc i=400000ff", valid2, instr_pc2, instr2);
    end
    step();
    n_cmp++;
    if (valid2 !== 1'b1 || instr_pc2 !== 32'h0 || instr2 !== 32'h100) begin
      n_fail++;
      $display("FAIL wrap_2: got v=%b pc=%h i=%h want v=1 pc=0 i=100", valid2, instr_pc2, instr2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (valid !== 1'b1 || imem_a !== 32'hC) begin
      n_fail++;
      $display("FAIL mid_pre: got v=%b a=%h want v=1 a=c", valid, imem_a);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (valid !== 1'b0 || imem_a !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async: got v=%b a=%h i=%h pc=%h want all 0", valid, imem_a, instr, instr_pc);
    end
    step();
    reset = 1'b0; ready = 1'b1;
    step();
    n_cmp++;
    if (valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h100) begin
      n_fail++;
      $display("FAIL mid_resume: got v=%b pc=%h i=%h want v=1 pc=0 i=100", valid, instr_pc, instr);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; reset2 = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the prefetch queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port imem_a  output  32  byte address to instruction memory, word-aligned.
REQ-006 The module SHALL have port imem_rd  input  32  instruction word returned combinationally for imem_a.
REQ-007 The module SHALL have port redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-008 The module SHALL have port redirect_pc  input  32  new fetch byte address.
REQ-009 The module SHALL have port instr_valid  output  1  queue head holds a valid instruction.
REQ-010 The module SHALL have port instr_ready  input  1  consumer accepts head this cycle.
REQ-011 The module SHALL have port instr  output  32  instruction word at queue head.
REQ-012 The module SHALL have port instr_pc  output  32  byte address of instr.
REQ-013 The module SHALL have port fault  output  1  sticky misaligned-redirect flag.

Function
REQ-014 imem_a SHALL equal fetch_pc combinationally; fetch_pc[1:0] SHALL always be 2'b00.
REQ-015 Enqueue SHALL occur when (count<DEPTH or pop) and not redirect and not fault: capture {fetch_pc, imem_rd}; fetch_pc += 4.
REQ-016 fetch_pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 Pop SHALL occur when instr_valid and instr_ready and not redirect; head advances one entry.
REQ-018 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL read 32'h0 when instr_valid=0.
REQ-019 Full queue with pop in the same cycle SHALL enqueue and pop together; count unchanged.
REQ-020 Empty queue SHALL never pop; the enqueued word appears at the head the next cycle (1-cycle fetch-to-valid latency).
REQ-021 Redirect SHALL have priority: queue emptied, fetch_pc <= {redirect_pc[31:2],2'b00}, no enqueue or pop that cycle; a handshake coinciding with redirect is void.
REQ-022 After redirect, instr_valid SHALL be 0 for exactly one cycle, then the word at redirect_pc appears with instr_pc=redirect_pc.
REQ-023 Outputs SHALL hold stable while instr_valid=1 and instr_ready=0, except on redirect.
REQ-024 Queue pointers SHALL wrap modulo DEPTH; count width SHALL be $clog2(DEPTH+1).

Reset
REQ-025 On reset assertion, immediately and regardless of clk: fetch_pc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, fault=0, imem_a=RESET_PC.
REQ-026 Reset mid-operation SHALL discard all queued entries; fetching resumes at RESET_PC on the first rising edge after deassertion.

Configuration
REQ-027 With IFETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 SHALL set fault, flush the queue and stop enqueue until an aligned redirect clears fault.
REQ-028 Without IFETCH_MISALIGN_EN: fault SHALL be tied 0 and redirect_pc[1:0] ignored per REQ-021.

Structure
REQ-029 Package ifetch_pkg SHALL hold XLEN=32, INSTR_BYTES=4 and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
REQ-030 Queue storage and pointers SHALL be sub-module ifetch_fifo (parameter DEPTH, fetch_entry_t payload); ifetch_unit holds fetch_pc, control and fault.

Verification
REQ-031 Reset, ROM[i]=i+0x100, instr_ready=1 -> from cycle 1 after reset instr_pc 0,4,8,... with instr 0x100,0x101,... one per cycle.
REQ-032 instr_ready=0 for 10 cycles -> DEPTH=4 entries held, imem_a stalls at 0x10, instr stable at pc 0; release -> 0,4,8,C,10 in order, no gap.
REQ-033 redirect=1, redirect_pc=0x40 with full queue and instr_ready=1 -> no pop counted, instr_valid=0 next cycle, then instr_pc=0x40, 0x44.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 IFETCH_MISALIGN_EN, redirect_pc=0x42 -> fault=1, instr_valid stays 0; redirect_pc=0x80 -> fault=0, instr_pc=0x80 two cycles later.
REQ-036 Assert reset mid-stream with 3 entries queued -> instr_valid=0 and imem_a=RESET_PC immediately, before next clk edge.
